if_fetch_ctrl: RTL and testbench

Sequencer for the instruction-fetch stage. It owns the PC and drives a req/ack instruction-memory port. It absorbs decode stalls through a one-entry hold buffer and applies branch redirects from EX. It produces the IF/ID pipeline register {pc, instr} with a valid bit, plus a delivered-instruction counter for the pipeline front end.

---
 rtl/if_pkg.sv | 20 ++
 rtl/if_fetch_ctrl_if.sv | 26 ++
 rtl/if_hold_buf.sv | 41 ++++
 rtl/if_fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and its bench.
package if_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam int          IF_ID_W   = 64;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Instruction addresses are word aligned; low bits are dropped, not trapped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory port between the fetch sequencer (master) and memory (slave).
interface if_fetch_ctrl_if;

  // imem_req is held with a stable imem_addr until the cycle imem_ack=1; that
  // cycle completes the transfer and imem_rdata is sampled only then. imem_ack
  // may be a combinational function of imem_req in the same cycle.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_hold_buf.sv
// One-entry {pc, instr} skid register that parks a fetched word behind a decode stall.
module if_hold_buf
  import if_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [IF_ID_W-1:0] din,
  output logic [IF_ID_W-1:0] dout,
  output logic               valid
);

  logic [IF_ID_W-1:0] data_q, data_d;
  logic               valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      data_d  = din;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dout  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the imem port, and fills the
// IF/ID register while absorbing decode stalls and EX redirects.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  if_fetch_ctrl_if.master      imem,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  output logic [IF_ID_W-1:0]   reg_if_id,
  output logic                 if_id_valid,
  output logic [31:0]          fetch_count,
  output state_t               dbg_state
);

  state_t              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         pend_q, pend_d;
  logic [IF_ID_W-1:0]  if_id_q, if_id_d;
  logic                valid_q, valid_d;
  logic [31:0]         count_q, count_d;

  logic                buf_load, buf_clear, buf_valid;
  logic [IF_ID_W-1:0]  buf_dout;
  logic                word_avail;
  logic [IF_ID_W-1:0]  word;
  logic [31:0]         target;

  if_hold_buf u_hold_buf (
    .clk   (clk),
    .reset (reset),
    .load  (buf_load),
    .clear (buf_clear),
    .din   ({pc_q, imem.imem_rdata}),
    .dout  (buf_dout),
    .valid (buf_valid)
  );

  assign target = align_pc(redirect_pc);

  // Sequencer: next state, PC, and which word (if any) is offered to IF/ID.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pend_d         = pend_q;
    buf_load       = 1'b0;
    buf_clear      = 1'b0;
    word_avail     = 1'b0;
    word           = '0;
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc_q;

    case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (redirect) pc_d = target;
      end
      FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) begin
          if (redirect) begin
            pc_d = target;
          end else begin
            pc_d = pc_q + PC_STEP;
            if (stall) begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end else begin
              word_avail = 1'b1;
              word       = {pc_q, imem.imem_rdata};
            end
          end
        end else if (redirect) begin
          pend_d  = target;
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (redirect) begin
          buf_clear = 1'b1;
          pc_d      = target;
          state_d   = FETCH;
        end else if (!stall) begin
          word_avail = buf_valid;
          word       = buf_dout;
          buf_clear  = 1'b1;
          state_d    = FETCH;
        end
      end
      DRAIN: begin
        // The old request must complete before the target can be fetched.
        imem.imem_req = 1'b1;
        if (redirect) pend_d = target;
        if (imem.imem_ack) begin
          pc_d    = redirect ? target : pend_q;
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // IF/ID update: redirect beats stall, stall beats a new word.
  always_comb begin
    if_id_d = if_id_q;
    valid_d = valid_q;
    count_d = count_q;
    if (redirect) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      if (word_avail) begin
        if_id_d = word;
        valid_d = 1'b1;
        count_d = count_q + 32'd1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= RESET_PC;
      if_id_q <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      if_id_q <= if_id_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign reg_if_id   = if_id_q;
  assign if_id_valid = valid_q;
  assign fetch_count = count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: two instances (RESET_PC 0 and 0x100) share stimulus.
module tb_if_fetch_ctrl;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [3:0]  mem_lat;

  logic [63:0] reg0, reg1;
  logic        val0, val1;
  logic [31:0] cnt0, cnt1;
  state_t      st0, st1;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_ctrl_if m0 ();
  if_fetch_ctrl_if m1 ();

  if_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .reset(reset), .imem(m0), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .reg_if_id(reg0), .if_id_valid(val0),
    .fetch_count(cnt0), .dbg_state(st0)
  );

  if_fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut1 (
    .clk(clk), .reset(reset), .imem(m1), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .reg_if_id(reg1), .if_id_valid(val1),
    .fetch_count(cnt1), .dbg_state(st1)
  );

  always #5 clk = ~clk;

  // Memory model: ack after mem_lat waiting cycles (0 = same cycle), data = addr ^ A5A5_0000.
  logic [3:0] wc0, wc1;
  assign m0.imem_ack   = m0.imem_req && (wc0 == mem_lat);
  assign m0.imem_rdata = m0.imem_addr ^ 32'hA5A5_0000;
  assign m1.imem_ack   = m1.imem_req && (wc1 == mem_lat);
  assign m1.imem_rdata = m1.imem_addr ^ 32'hA5A5_0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wc0 <= '0;
      wc1 <= '0;
    end else begin
      if (m0.imem_req && m0.imem_ack) wc0 <= '0;
      else if (m0.imem_req)           wc0 <= wc0 + 4'd1;
      if (m1.imem_req && m1.imem_ack) wc1 <= '0;
      else if (m1.imem_req)           wc1 <= wc1 + 4'd1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; mem_lat = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   64'(m0.imem_req), 64'd0);
    chk("rst_addr",  64'(m0.imem_addr), 64'h0);
    chk("rst_reg",   reg0, 64'h0);
    chk("rst_valid", 64'(val0), 64'd0);
    chk("rst_count", 64'(cnt0), 64'd0);
    chk("rst_state", 64'(st0), 64'(BOOT));
    chk("rst_addr_b", 64'(m1.imem_addr), 64'h100);

    // Zero-latency memory
    reset = 1'b0;
    chk("boot_req", 64'(m0.imem_req), 64'd0);
    step();
    chk("c2_req",   64'(m0.imem_req), 64'd1);
    chk("c2_addr",  64'(m0.imem_addr), 64'h0);
    chk("c2_valid", 64'(val0), 64'd0);
    step();
    chk("c3_valid", 64'(val0), 64'd1);
    chk("c3_reg",   reg0, 64'h0000_0000_A5A5_0000);
    chk("c3_count", 64'(cnt0), 64'd1);
    chk("c3_addr",  64'(m0.imem_addr), 64'h4);
    step();
    chk("c4_reg",   reg0, 64'h0000_0004_A5A5_0004);
    chk("c4_count", 64'(cnt0), 64'd2);
    step();
    chk("c5_reg",   reg0, 64'h0000_0008_A5A5_0008);
    chk("c5_count", 64'(cnt0), 64'd3);
    chk("c5_addr",  64'(m0.imem_addr), 64'hC);

    // Three-cycle memory latency
    mem_lat = 4'd2;
    step();
    chk("lat_w1_valid", 64'(val0), 64'd0);
    chk("lat_w1_addr",  64'(m0.imem_addr), 64'hC);
    step();
    chk("lat_w2_valid", 64'(val0), 64'd0);
    chk("lat_w2_addr",  64'(m0.imem_addr), 64'hC);
    chk("lat_w2_req",   64'(m0.imem_req), 64'd1);
    step();
    chk("lat_reg",   reg0, 64'h0000_000C_A5A5_000C);
    chk("lat_valid", 64'(val0), 64'd1);
    chk("lat_count", 64'(cnt0), 64'd4);
    chk("lat_addr",  64'(m0.imem_addr), 64'h10);

    // Stall for 4 cycles across the ack at 0x10
    mem_lat = 4'd0;
    stall = 1'b1;
    step();
    chk("stl_state", 64'(st0), 64'(HOLD));
    chk("stl_req",   64'(m0.imem_req), 64'd0);
    chk("stl_reg1",  reg0, 64'h0000_000C_A5A5_000C);
    chk("stl_val1",  64'(val0), 64'd1);
    chk("stl_cnt1",  64'(cnt0), 64'd4);
    step();
    chk("stl_reg2",  reg0, 64'h0000_000C_A5A5_000C);
    step();
    chk("stl_reg3",  reg0, 64'h0000_000C_A5A5_000C);
    step();
    stall = 1'b0;
    chk("stl_reg4",  reg0, 64'h0000_000C_A5A5_000C);
    chk("stl_val4",  64'(val0), 64'd1);
    step();
    chk("rel_reg",   reg0, 64'h0000_0010_A5A5_0010);
    chk("rel_count", 64'(cnt0), 64'd5);
    chk("rel_req",   64'(m0.imem_req), 64'd1);
    chk("rel_addr",  64'(m0.imem_addr), 64'h14);
    step();
    chk("rel2_reg",   reg0, 64'h0000_0014_A5A5_0014);
    chk("rel2_count", 64'(cnt0), 64'd6);
    step();
    chk("c15_reg", reg0, 64'h0000_0018_A5A5_0018);
    step();
    chk("c16_reg",  reg0, 64'h0000_001C_A5A5_001C);
    chk("c16_addr", 64'(m0.imem_addr), 64'h20);

    // Redirect while the request at 0x20 is pending
    mem_lat = 4'd2;
    step();
    chk("pend_valid", 64'(val0), 64'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    step();
    redirect = 1'b0;
    chk("drn_state", 64'(st0), 64'(DRAIN));
    chk("drn_req",   64'(m0.imem_req), 64'd1);
    chk("drn_addr",  64'(m0.imem_addr), 64'h20);
    chk("drn_valid", 64'(val0), 64'd0);
    step();
    chk("tgt_state", 64'(st0), 64'(FETCH));
    chk("tgt_addr",  64'(m0.imem_addr), 64'h200);
    chk("tgt_valid", 64'(val0), 64'd0);
    chk("tgt_count", 64'(cnt0), 64'd8);
    step();
    chk("tgt_w1_valid", 64'(val0), 64'd0);
    step();
    chk("tgt_w2_valid", 64'(val0), 64'd0);
    step();
    chk("tgt_reg",   reg0, 64'h0000_0200_A5A5_0200);
    chk("tgt_val",   64'(val0), 64'd1);
    chk("tgt_cnt",   64'(cnt0), 64'd9);

    // Redirect together with stall while in HOLD
    mem_lat = 4'd0;
    stall = 1'b1;
    step();
    chk("hr_state", 64'(st0), 64'(HOLD));
    chk("hr_reg",   reg0, 64'h0000_0200_A5A5_0200);
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    step();
    redirect = 1'b0; stall = 1'b0;
    chk("hr_valid", 64'(val0), 64'd0);
    chk("hr_reg2",  reg0, 64'h0000_0200_A5A5_0200);
    chk("hr_addr",  64'(m0.imem_addr), 64'h300);
    chk("hr_cnt",   64'(cnt0), 64'd9);
    step();
    chk("hr_tgt_reg", reg0, 64'h0000_0300_A5A5_0300);
    chk("hr_tgt_cnt", 64'(cnt0), 64'd10);
    step();
    chk("hr_next_reg", reg0, 64'h0000_0304_A5A5_0304);
    chk("hr_next_cnt", 64'(cnt0), 64'd11);

    // Same-cycle ack+redirect, then PC wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    chk("wr_addr",  64'(m0.imem_addr), 64'hFFFF_FFFC);
    chk("wr_valid", 64'(val0), 64'd0);
    chk("wr_cnt",   64'(cnt0), 64'd11);
    step();
    chk("wr_reg",   reg0, 64'hFFFF_FFFC_5A5A_FFFC);
    chk("wr_cnt2",  64'(cnt0), 64'd12);
    chk("wr_addr2", 64'(m0.imem_addr), 64'h0);

    // Reset asserted while in DRAIN
    mem_lat = 4'd2;
    redirect = 1'b1; redirect_pc = 32'h0000_0400;
    step();
    redirect = 1'b0;
    chk("rd_state", 64'(st0), 64'(DRAIN));
    reset = 1'b1; mem_lat = 4'd0;
    #1;
    chk("rd_state0", 64'(st0), 64'(BOOT));
    chk("rd_req0",   64'(m0.imem_req), 64'd0);
    chk("rd_addr0",  64'(m0.imem_addr), 64'h0);
    chk("rd_reg0",   reg0, 64'h0);
    chk("rd_val0",   64'(val0), 64'd0);
    chk("rd_cnt0",   64'(cnt0), 64'd0);
    chk("rd_addr1",  64'(m1.imem_addr), 64'h100);
    chk("rd_reg1",   reg1, 64'h0);
    chk("rd_cnt1",   64'(cnt1), 64'd0);
    step();
    reset = 1'b0;
    chk("rb_state1", 64'(st1), 64'(BOOT));
    chk("rb_req1",   64'(m1.imem_req), 64'd0);
    step();
    chk("rb_req1b",  64'(m1.imem_req), 64'd1);
    chk("rb_addr1",  64'(m1.imem_addr), 64'h100);
    step();
    chk("rb_reg1",   reg1, 64'h0000_0100_A5A5_0100);
    chk("rb_val1",   64'(val1), 64'd1);
    chk("rb_cnt1",   64'(cnt1), 64'd1);
    chk("rb_reg0",   reg0, 64'h0000_0000_A5A5_0000);
    chk("rb_cnt0",   64'(cnt0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
